// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pkg
// Brief    : Shared sensor-word definitions for the debounce stage and the
//            priority-to-seven-segment decoder downstream of it.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    localparam int SENSOR_W             = 8;
    localparam int DEFAULT_STABLE_TICKS = 16;

    typedef logic [SENSOR_W-1:0] sensor_word_t;

endpackage : sensor_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Brief    : One sensor line: two-flop synchroniser, stability counter and
//            debounced level flop. Reports the flip about to happen on this
//            edge and whether its next-state counter is idle.
//            SENSOR_DEBOUNCE_EN selects counter-based debouncing; without it
//            the level simply follows the synchronised line on sample ticks.
// Revision : 1.0 - initial release
// ============================================================================
import sensor_pkg::*;

module debounce_bit
`ifdef SENSOR_DEBOUNCE_EN
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic sample_en,
    output logic level,
    output logic flip
`ifdef SENSOR_DEBOUNCE_EN
    ,
    output logic idle
`endif
);

    logic r_s1;
    logic r_s2;
    logic r_level;
    logic w_mismatch;
    logic w_flip;

    // Two-flop synchroniser, free-running regardless of sample_en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    assign w_mismatch = (r_s2 != r_level);

`ifdef SENSOR_DEBOUNCE_EN
    localparam int              CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Next counter value: clear on match, count on mismatch, accept at last tick
    always_comb begin
        w_cnt_next = r_cnt;
        w_flip     = 1'b0;
        if (sample_en) begin
            if (!w_mismatch) begin
                w_cnt_next = '0;
            end else if (r_cnt == c_last) begin
                w_cnt_next = '0;
                w_flip     = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // Stability counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign idle = (w_cnt_next == '0);
`else
    // Without debouncing every sampled difference is accepted immediately
    assign w_flip = sample_en & w_mismatch;
`endif

    // Debounced level: toggling on a flip means taking the synchronised value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= 1'b0;
        end else if (w_flip) begin
            r_level <= r_s2;
        end
    end

    assign level = r_level;
    assign flip  = w_flip;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Brief    : Input conditioning for the 8-line level-sensor word. Each line is
//            synchronised and debounced; a registered level word is produced
//            along with a one-cycle change pulse and a stability flag.
//            Build macro SENSOR_DEBOUNCE_EN enables the per-line counters;
//            when undefined the level tracks the synchronised lines and
//            stable is held at 1.
// Revision : 1.0 - initial release
// ============================================================================
import sensor_pkg::*;

module sensor_debounce #(
    parameter int WIDTH        = SENSOR_W,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    input  logic             sample_en,
    output logic [WIDTH-1:0] level,
    output logic             changed,
    output logic             stable
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_flip;
    logic             w_stable_next;
    logic             r_changed;
    logic             r_stable;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
`ifdef SENSOR_DEBOUNCE_EN
        logic w_idle;

        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (raw[i]),
            .sample_en (sample_en),
            .level     (w_level[i]),
            .flip      (w_flip[i]),
            .idle      (w_idle)
        );
`else
        debounce_bit u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (raw[i]),
            .sample_en (sample_en),
            .level     (w_level[i]),
            .flip      (w_flip[i])
        );
`endif
    end

`ifdef SENSOR_DEBOUNCE_EN
    logic [WIDTH-1:0] w_idle_vec;

    for (genvar j = 0; j < WIDTH; j++) begin : g_idle
        assign w_idle_vec[j] = g_line[j].w_idle;
    end

    // Stable only when nothing is pending and nothing is completing this edge
    assign w_stable_next = (&w_idle_vec) & ~(|w_flip);
`else
    // Stable has no meaning without counters
    assign w_stable_next = 1'b1;
    // Keep the unused tick count visibly consumed in this build
    logic w_unused_ticks;
    assign w_unused_ticks = (STABLE_TICKS == 0);
`endif

    // Register the change pulse and stability flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
            r_stable  <= 1'b1;
        end else begin
            r_changed <= |w_flip;
            r_stable  <= w_stable_next;
        end
    end

    assign level   = w_level;
    assign changed = r_changed;
    assign stable  = r_stable;

endmodule : sensor_debounce
`default_nettype wire
